// File: rtl/posicionador_de_navios.sv
// Ship-placement writer for the naval battle game: validates each confirmed
// placement against the board bounds and the ships already placed, then commits or rejects it.
module posicionador_de_navios #(
  parameter int unsigned TAM_NAVIO0 = 3,
  parameter int unsigned TAM_NAVIO1 = 2,
  parameter int unsigned TAM_NAVIO2 = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       orientacao,
  input  logic       confirmar,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [1:0] navio_atual,
  output logic       pronto,
  output logic       LED_R,
  output logic       LED_G
);

  localparam logic [3:0] TAM0 = 4'(TAM_NAVIO0);
  localparam logic [3:0] TAM1 = 4'(TAM_NAVIO1);
  localparam logic [3:0] TAM2 = 4'(TAM_NAVIO2);

  typedef enum logic [2:0] {ESPERA, VERIFICA, GRAVA, REJEITA, FIM} estado_t;

  estado_t          estado_q, estado_d;
  logic             confirmar_q;
  logic [2:0]       col_q, col_d;
  logic [2:0]       lin_q, lin_d;
  logic             ori_q, ori_d;
  logic [3:0]       tam_q, tam_d;
  logic [4:0][6:0]  mapa_q, mapa_d;
  logic [4:0][6:0]  pegada_q, pegada_d;
  logic [1:0]       navio_q, navio_d;
  logic             pronto_q, pronto_d;
  logic             led_r_q, led_r_d;
  logic             led_g_q, led_g_d;

  logic             evento;
  logic [3:0]       tam_atual;
  logic [6:0]       linhas_v;
  logic [6:0]       bit_h;
  logic [4:0]       colunas_h;
  logic [4:0]       col_sel;
  logic [4:0][6:0]  pegada;
  logic             fora;
  logic             sobre;

  assign evento    = confirmar & ~confirmar_q;
  assign tam_atual = (navio_q == 2'd0) ? TAM0 : (navio_q == 2'd1) ? TAM1 : TAM2;

  // Footprint of the latched placement: a run of rows in one column (vertical)
  // or one row across a run of columns (horizontal).
  assign linhas_v  = 7'((((16'd1 << tam_q) - 16'd1) << lin_q));
  assign bit_h     = 7'((16'd1 << lin_q));
  assign colunas_h = 5'((((16'd1 << tam_q) - 16'd1) << col_q));
  assign col_sel   = 5'((16'd1 << col_q));

  for (genvar k = 0; k < 5; k++) begin : g_coluna
    assign pegada[k] = ori_q ? (col_sel[k]   ? linhas_v : 7'd0)
                             : (colunas_h[k] ? bit_h    : 7'd0);
  end

  assign fora  = (col_q > 3'd4) || (lin_q > 3'd6)
              || (!ori_q && (({1'b0, col_q} + tam_q - 4'd1) > 4'd4))
              || ( ori_q && (({1'b0, lin_q} + tam_q - 4'd1) > 4'd6));
  assign sobre = |(pegada & mapa_q);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a value unassigned (no latches).
    estado_d = estado_q;
    col_d    = col_q;
    lin_d    = lin_q;
    ori_d    = ori_q;
    tam_d    = tam_q;
    mapa_d   = mapa_q;
    pegada_d = pegada_q;
    navio_d  = navio_q;
    pronto_d = pronto_q;
    led_r_d  = led_r_q;
    led_g_d  = led_g_q;
    case (estado_q)
      ESPERA: begin
        if (evento && !pronto_q) begin
          estado_d = VERIFICA;
          col_d    = coordColuna;
          lin_d    = coordLinha;
          ori_d    = orientacao;
          tam_d    = tam_atual;
        end
      end
      VERIFICA: begin
        pegada_d = pegada;
        estado_d = (fora || sobre) ? REJEITA : GRAVA;
      end
      GRAVA: begin
        mapa_d  = mapa_q | pegada_q;
        navio_d = navio_q + 2'd1;
        led_g_d = 1'b1;
        led_r_d = 1'b0;
        if (navio_q == 2'd2) begin
          pronto_d = 1'b1;
          estado_d = FIM;
        end else begin
          estado_d = ESPERA;
        end
      end
      REJEITA: begin
        led_r_d  = 1'b1;
        led_g_d  = 1'b0;
        estado_d = ESPERA;
      end
      FIM:     estado_d = FIM;
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state is only ever updated with <= so every flop samples pre-edge values.
    if (reset) begin
      estado_q    <= ESPERA;
      confirmar_q <= 1'b0;
      col_q       <= '0;
      lin_q       <= '0;
      ori_q       <= 1'b0;
      tam_q       <= '0;
      mapa_q      <= '0;
      pegada_q    <= '0;
      navio_q     <= '0;
      pronto_q    <= 1'b0;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
    end else if (!enable) begin
      // The button is still tracked so a press held across enable gives no event.
      estado_q    <= ESPERA;
      confirmar_q <= confirmar;
      col_q       <= '0;
      lin_q       <= '0;
      ori_q       <= 1'b0;
      tam_q       <= '0;
      mapa_q      <= '0;
      pegada_q    <= '0;
      navio_q     <= '0;
      pronto_q    <= 1'b0;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      confirmar_q <= confirmar;
      col_q       <= col_d;
      lin_q       <= lin_d;
      ori_q       <= ori_d;
      tam_q       <= tam_d;
      mapa_q      <= mapa_d;
      pegada_q    <= pegada_d;
      navio_q     <= navio_d;
      pronto_q    <= pronto_d;
      led_r_q     <= led_r_d;
      led_g_q     <= led_g_d;
    end
  end

  assign mapa0       = mapa_q[0];
  assign mapa1       = mapa_q[1];
  assign mapa2       = mapa_q[2];
  assign mapa3       = mapa_q[3];
  assign mapa4       = mapa_q[4];
  assign navio_atual = navio_q;
  assign pronto      = pronto_q;
  assign LED_R       = led_r_q;
  assign LED_G       = led_g_q;

endmodule

// File: tb/tb_posicionador_de_navios.sv
// Bench for posicionador_de_navios: directed table, multi-cycle corner cases and
// random placements compared with a board-level model of the placement rules.
module tb_posicionador_de_navios;

  logic       clock = 1'b0;
  logic       reset, enable, orientacao, confirmar;
  logic [2:0] coordColuna, coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [1:0] navio_atual;
  logic       pronto, LED_R, LED_G;

  always #5 clock = ~clock;

  posicionador_de_navios dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .orientacao  (orientacao),
    .confirmar   (confirmar),
    .mapa0       (mapa0),
    .mapa1       (mapa1),
    .mapa2       (mapa2),
    .mapa3       (mapa3),
    .mapa4       (mapa4),
    .navio_atual (navio_atual),
    .pronto      (pronto),
    .LED_R       (LED_R),
    .LED_G       (LED_G)
  );

  // {maps col4..col0, navio_atual, pronto, LED_R, LED_G}
  logic [39:0] dut_st;
  assign dut_st = {mapa4, mapa3, mapa2, mapa1, mapa0, navio_atual, pronto, LED_R, LED_G};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Board model: a 5x7 grid of occupied cells plus placement bookkeeping.
  bit mdl_map[5][7];
  int mdl_count;
  bit mdl_pronto, mdl_r, mdl_g;
  int tam_tab[3] = '{3, 2, 1};

  function automatic void mdl_clear();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) mdl_map[c][r] = 1'b0;
    mdl_count  = 0;
    mdl_pronto = 1'b0;
    mdl_r      = 1'b0;
    mdl_g      = 1'b0;
  endfunction

  function automatic void mdl_press(input int c, input int l, input bit o);
    int tam;
    bit fora, sobre;
    if (mdl_pronto) return;
    tam   = tam_tab[mdl_count];
    fora  = (c > 4) || (l > 6) || (!o && c + tam - 1 > 4) || (o && l + tam - 1 > 6);
    sobre = 1'b0;
    if (!fora)
      for (int k = 0; k < tam; k++)
        if (mdl_map[o ? c : c + k][o ? l + k : l]) sobre = 1'b1;
    if (fora || sobre) begin
      mdl_r = 1'b1;
      mdl_g = 1'b0;
    end else begin
      for (int k = 0; k < tam; k++) mdl_map[o ? c : c + k][o ? l + k : l] = 1'b1;
      mdl_count++;
      mdl_r = 1'b0;
      mdl_g = 1'b1;
      if (mdl_count == 3) mdl_pronto = 1'b1;
    end
  endfunction

  function automatic logic [39:0] mdl_pack();
    logic [39:0] v = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) v[5 + c * 7 + r] = mdl_map[c][r];
    v[4:3] = 2'(mdl_count);
    v[2]   = mdl_pronto;
    v[1]   = mdl_r;
    v[0]   = mdl_g;
    return v;
  endfunction

  typedef struct {
    string      name;
    int         c;
    int         l;
    bit         o;
    logic [6:0] m0, m1, m2, m3, m4;
    logic [1:0] navio;
    bit         pronto, r, g;
  } vec_t;

  vec_t tbl[6];

  // Called on a falling edge; returns on a falling edge with the verdict settled.
  task automatic press(input int c, input int l, input bit o);
    coordColuna = 3'(c);
    coordLinha  = 3'(l);
    orientacao  = o;
    confirmar   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mdl_clear();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; confirmar = 1'b0;
    orientacao = 1'b0; coordColuna = '0; coordLinha = '0;
    mdl_clear();

    tbl[0] = '{"ship0_h_00",   0, 0, 1'b0, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00,         2'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{"ship1_oob",    4, 6, 1'b1, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00,         2'd1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{"ship1_overlap",1, 0, 1'b1, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00,         2'd1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{"ship1_v_45",   4, 5, 1'b1, 7'h01, 7'h01, 7'h01, 7'h00, 7'b1100000,    2'd2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{"ship2_33",     3, 3, 1'b0, 7'h01, 7'h01, 7'h01, 7'b0001000, 7'b1100000, 2'd3, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{"fim_ignored",  0, 6, 1'b0, 7'h01, 7'h01, 7'h01, 7'b0001000, 7'b1100000, 2'd3, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clock);
    check("reset_state", dut_st, 40'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      press(tbl[i].c, tbl[i].l, tbl[i].o);
      check(tbl[i].name, dut_st, {tbl[i].m4, tbl[i].m3, tbl[i].m2, tbl[i].m1, tbl[i].m0,
                                  tbl[i].navio, tbl[i].pronto, tbl[i].r, tbl[i].g});
    end

    // Latency: nothing visible after two edges, committed on the third.
    do_reset();
    mdl_press(0, 0, 1'b1);
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b1; confirmar = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("latency_early", dut_st, 40'd0);
    @(posedge clock);
    @(negedge clock);
    check("latency_commit", dut_st, mdl_pack());
    confirmar = 1'b0;
    @(negedge clock);

    // Button held ten cycles, coordinates moved mid-hold: one placement only.
    do_reset();
    mdl_press(0, 0, 1'b1);
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b1; confirmar = 1'b1;
    repeat (4) @(negedge clock);
    coordColuna = 3'd2;
    repeat (6) @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    check("held_button", dut_st, mdl_pack());

    // Second press landing while the first is in GRAVA is dropped.
    do_reset();
    mdl_press(0, 0, 1'b0);
    coordColuna = 3'd0; coordLinha = 3'd0; orientacao = 1'b0; confirmar = 1'b1;
    @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    coordLinha = 3'd3; confirmar = 1'b1;
    repeat (5) @(negedge clock);
    confirmar = 1'b0;
    @(negedge clock);
    check("busy_press_dropped", dut_st, mdl_pack());

    // enable dropped while VERIFICA holds a placement.
    do_reset();
    press(0, 0, 1'b0);
    coordColuna = 3'd1; coordLinha = 3'd1; orientacao = 1'b0; confirmar = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    confirmar = 1'b0;
    @(negedge clock);
    check("enable_drop_clear", dut_st, 40'd0);
    enable = 1'b1;
    repeat (4) @(negedge clock);
    check("enable_no_commit", dut_st, 40'd0);

    // Random placements against the board model.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int c, l;
      bit o;
      c = int'($urandom_range(0, 7));
      l = int'($urandom_range(0, 7));
      o = 1'($urandom_range(0, 1));
      press(c, l, o);
      mdl_press(c, l, o);
      check($sformatf("rand_%0d_c%0d_l%0d_o%0d", i, c, l, o), dut_st, mdl_pack());
      if (mdl_pronto && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
